// File: rtl/au_seq_if.sv
// Operand/control and flag/handshake bundle for the sequenced arithmetic unit.
// The tri-state result bus is kept outside so it can resolve with other bus drivers.
interface au_seq_if #(parameter int WIDTH = 8);
  logic             au_en;
  logic             start;
  logic [3:0]       ac;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gf;
  logic             cf;
  logic             zf;
  logic             busy;
  logic             done;

  modport master (output au_en, start, ac, a, b,
                  input  gf, cf, zf, busy, done);
  modport slave  (input  au_en, start, ac, a, b,
                  output gf, cf, zf, busy, done);
endinterface

// File: rtl/au_seq.sv
// Clocked arithmetic unit: add/sub/pass in one EXEC cycle, shift-add multiply over WIDTH cycles.
// Result and flags are registered; t drives the shared bus only while au_en is high.
module au_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  au_seq_if.slave          bus,
  output wire  [WIDTH-1:0] t
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_ac;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_gf;
  logic               r_cf;
  logic               r_zf;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [CW-1:0]      r_cnt;

  logic               w_load;
  logic               w_wr;
  logic               w_flag_wr;
  logic               w_gf;
  logic               w_cf;
  logic               w_busy;
  logic               w_done;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_b} - {1'b0, r_a};
  // r_b is consumed LSB-first while r_mcand walks left, one partial product per cycle
  assign w_acc_nxt = r_acc + (r_b[0] ? r_mcand : '0);

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_wr      = 1'b0;
    w_flag_wr = 1'b0;
    w_res     = r_res;
    w_gf      = 1'b0;
    w_cf      = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (bus.start) begin
          w_load = 1'b1;
          w_next = (bus.ac == 4'b1010) ? S_MUL : S_EXEC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: begin
        w_busy    = 1'b1;
        w_flag_wr = 1'b1;
        w_next    = S_DONE;
        case (r_ac)
          4'b1000: begin
            w_wr  = 1'b1;
            w_res = w_sum[WIDTH-1:0];
            w_cf  = w_sum[WIDTH];
          end
          4'b1001: begin
            w_wr  = 1'b1;
            w_res = w_diff[WIDTH-1:0];
            w_gf  = ~w_diff[WIDTH];
            w_cf  = w_diff[WIDTH];
          end
          4'b0100, 4'b0101, 4'b1101: begin
            w_wr  = 1'b1;
            w_res = r_a;
          end
          default: ;  // illegal code: result and zero flag hold, gf/cf clear
        endcase
      end
      S_MUL: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_wr      = 1'b1;
          w_flag_wr = 1'b1;
          w_res     = w_acc_nxt[WIDTH-1:0];
          w_cf      = |w_acc_nxt[2*WIDTH-1:WIDTH];
          w_next    = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_gf    <= 1'b0;
      r_cf    <= 1'b0;
      r_zf    <= 1'b0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_ac    <= bus.ac;
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_mcand <= {{WIDTH{1'b0}}, bus.a};
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_MUL) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_b     <= r_b >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_wr) begin
        r_res <= w_res;
        r_zf  <= (w_res == '0);
      end
      if (w_flag_wr) begin
        r_gf <= w_gf;
        r_cf <= w_cf;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.gf   = r_gf;
  assign bus.cf   = r_cf;
  assign bus.zf   = r_zf;
  assign t        = bus.au_en ? r_res : 'z;

endmodule

// File: tb/tb_au_seq.sv
// Directed-vector bench for au_seq (WIDTH=8): latency, flags, back-to-back, bus gating, reset mid-multiply.
module tb_au_seq;

  logic       clk;
  logic       rst;
  wire  [7:0] t;

  au_seq_if #(.WIDTH(8)) bus ();

  au_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .t   (t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ac;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] t;
    logic       gf;
    logic       cf;
    logic       zf;
    int         lat;
    bit         toggle;
    bit         align;
    bit         tail;
  } vec_t;

  int   checks;
  int   errors;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Leaves the bench at the negedge of the DONE cycle (or of the following idle cycle when tail=1).
  task automatic run_op(input int idx, input vec_t v);
    int lat;
    int busy_n;
    bit seen;
    if (v.align) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.ac    = v.ac;
    bus.a     = v.a;
    bus.b     = v.b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (v.toggle) begin
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.ac    = 4'($urandom_range(15, 0));
        bus.start = (cyc >= 2 && cyc <= 4);
      end
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = cyc;
        break;
      end
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_n), 32'(v.lat - 1));
    chk($sformatf("v%0d_t", idx), 32'(t), 32'(v.t));
    chk($sformatf("v%0d_gf", idx), 32'(bus.gf), 32'(v.gf));
    chk($sformatf("v%0d_cf", idx), 32'(bus.cf), 32'(v.cf));
    chk($sformatf("v%0d_zf", idx), 32'(bus.zf), 32'(v.zf));
    if (v.tail) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_no_extra_done", idx), 32'(bus.done), 32'd0);
      chk($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.au_en = 1'b1;
    bus.start = 1'b0;
    bus.ac    = 4'b0000;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    //            ac       a      b      t      gf    cf    zf   lat tog aln tail
    tbl[0]  = '{4'b1000, 8'hC8, 8'h64, 8'h2C, 1'b0, 1'b1, 1'b0, 2, 0, 1, 1};
    tbl[1]  = '{4'b1001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 2, 0, 1, 0};
    tbl[2]  = '{4'b1001, 8'h06, 8'h05, 8'hFF, 1'b0, 1'b1, 1'b0, 2, 0, 0, 1};
    tbl[3]  = '{4'b1010, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 9, 0, 1, 1};
    tbl[4]  = '{4'b1010, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 9, 1, 1, 1};
    tbl[5]  = '{4'b1000, 8'hC8, 8'h64, 8'h2C, 1'b0, 1'b1, 1'b0, 2, 0, 1, 1};
    tbl[6]  = '{4'b0000, 8'h11, 8'h22, 8'h2C, 1'b0, 1'b0, 1'b0, 2, 0, 1, 1};
    tbl[7]  = '{4'b1001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 2, 0, 1, 1};
    tbl[8]  = '{4'b0111, 8'h05, 8'h09, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0, 1, 1};
    tbl[9]  = '{4'b1101, 8'h7E, 8'h01, 8'h7E, 1'b0, 1'b0, 1'b0, 2, 0, 1, 1};
    tbl[10] = '{4'b1000, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 2, 0, 1, 1};
    tbl[11] = '{4'b1010, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 9, 0, 1, 1};
    tbl[12] = '{4'b1000, 8'hC8, 8'h64, 8'h2C, 1'b0, 1'b1, 1'b0, 2, 0, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_t", 32'(t), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flags", 32'({bus.gf, bus.cf, bus.zf}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_op(i, tbl[i]);

    // Bus gating: res is 0x2C here; dropping au_en must release the bus without touching state.
    #2;
    bus.au_en = 1'b0;
    #1;
    checks++;
    if (t === 8'h2C) begin
      errors++;
      $display("FAIL en_off_t actual=%0h required=released", t);
    end
    chk("en_off_flags", 32'({bus.gf, bus.cf, bus.zf}), 32'b010);
    @(posedge clk); #1;
    chk("en_off_busy", 32'(bus.busy), 32'd0);
    bus.au_en = 1'b1;
    #1;
    chk("en_on_t", 32'(t), 32'h2C);
    chk("en_on_flags", 32'({bus.gf, bus.cf, bus.zf}), 32'b010);

    // Reset in cycle 4 of a multiply.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ac    = 4'b1010;
    bus.a     = 8'h0F;
    bus.b     = 8'h11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_flags", 32'({bus.gf, bus.cf, bus.zf}), 32'd0);
    chk("mrst_t", 32'(t), 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(100, '{4'b1000, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 2, 0, 1, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/au_seq.md
# au_seq

Parametrised, clocked successor to the datapath arithmetic unit. It executes add, subtract, pass and multi-cycle shift-add multiply on WIDTH-bit operands, under a start/busy/done handshake. Results and flags are held in registers and driven onto the shared data bus through a tri-state output gated by `au_en`. It sits between the operand registers and the internal data bus, sequenced by the controller.

## Interface
- `WIDTH`, 8, operand/result width in bits (>= 2)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `au_en`  in  1  bus output enable; `t` is high-Z when 0
- `start`  in  1  launch request; sampled only in IDLE or DONE
- `ac`  in  4  operation code, latched with `start`
- `a`, `b`  in  WIDTH  operands, latched with `start`
- `t`  out  WIDTH  tri-state result bus: `au_en ? res : 'z`
- `gf`  out  1  no-borrow flag (SUB: 1 iff b >= a)
- `cf`  out  1  carry / borrow / multiply-overflow flag
- `zf`  out  1  result-zero flag
- `busy`  out  1  high in EXEC and MUL states
- `done`  out  1  high for exactly one cycle in DONE state

## Operation
- Op codes:
  - 1000 ADD: `res = a+b`; `cf` = bit WIDTH of the (WIDTH+1)-bit sum; `gf=0`.
  - 1001 SUB: `res = b-a`, computed at WIDTH+1 bits; `gf` = ~bit WIDTH; `cf` = bit WIDTH (borrow).
  - 0100 / 0101 / 1101 PASS: `res = a`; `gf=cf=0`.
  - 1010 MUL: `res` = low WIDTH bits of a*b; `cf` = 1 iff high WIDTH bits are nonzero; `gf=0`.
  - Any other code is illegal: `res` is unchanged, `gf=cf=0`, `zf` is unchanged.
- `zf = (res == 0)` is updated whenever `res` is written.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE / DONE with `start=1`: latch `ac`, `a`, `b`. Go to MUL if `ac=1010`, else EXEC.
  - IDLE / DONE with `start=0`: go to (or stay in) IDLE.
  - EXEC: write `res` and flags, then go to DONE.
  - MUL: shift-add one multiplier bit per cycle using a 2·WIDTH accumulator and a cycle counter. After WIDTH cycles, write `res` and flags, then go to DONE.
- While busy:
  - `start` is ignored.
  - `a`, `b` and `ac` may change freely with no effect on the operation.
- `t` always presents the `res` register. During busy it shows the previous result.
- `au_en` affects only the bus driver, never the FSM, `res` or the flags.
- Reset, asynchronous at any time including mid-MUL:
  - state = IDLE, `res = 0`, `gf = cf = zf = 0`, `busy = 0`, `done = 0`.
  - Accumulator and counter are cleared.
  - With `au_en=1`, `t` reads 0.

## Timing
- Let edge 0 be the edge that samples `start`.
- Single-cycle ops:
  - `busy` is high in cycle 1.
  - `res` and flags are valid after edge 1.
  - `done` is high in cycle 2.
- MUL:
  - `busy` is high in cycles 1..WIDTH.
  - `res` and flags are valid after edge WIDTH.
  - `done` is high in cycle WIDTH+1.
- Back-to-back: `start` held in the DONE cycle is accepted. Throughput is one single-cycle op every 2 cycles.
- `t` tri-state response is combinational from `au_en`; no clock involved.

## Test plan
All scenarios use WIDTH=8.
- ADD, a=0xC8, b=0x64 → t=0x2C, cf=1, gf=0, zf=0; busy in cycle 1 only; done in cycle 2 only.
- SUB, a=0x05, b=0x05 → t=0x00, gf=1, cf=0, zf=1. Then SUB issued in the DONE cycle, a=0x06, b=0x05 → t=0xFF, gf=0, cf=1, zf=0; back-to-back start accepted.
- MUL:
  - a=0x0F, b=0x11 → t=0xFF, cf=0; busy for cycles 1–8; done exactly in cycle 9.
  - a=0x10, b=0x10 → t=0x00, cf=1, zf=1.
  - Toggling a, b, ac and pulsing start during busy → results unchanged, no extra done.
- au_en=0 with res=0x2C → t=Z. Raising au_en → t=0x2C immediately; flags and state unaffected by au_en.
- Illegal op ac=0000 after a result of 0x2C → done in cycle 2, t stays 0x2C, gf=cf=0, zf unchanged. PASS with ac=1101, a=0x7E → t=0x7E.
- rst asserted in cycle 4 of a MUL → immediately busy=0, done=0, gf=cf=zf=0, t=0x00 (au_en=1); after release, a new ADD completes normally.
